// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, valid/ready byte hold, framing and overrun flags
module uart_rx #(
   parameter int CLOCK_FREQ = 30000000,
   parameter int BAUD_RATE  = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       ready,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int BIT_CYCLES  = CLOCK_FREQ / BAUD_RATE + 1;
   localparam int HALF_CYCLES = BIT_CYCLES / 2;
   localparam int CNT_W       = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync1_d;
   logic             rxs_q, rxs_d;
   logic             hist_q, hist_d;
   logic [1:0]       flush_q, flush_d;
   logic             armed_q, armed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;

   always_comb begin
      sync1_d     = rx;
      rxs_d       = sync1_q;
      hist_d      = rxs_q;
      // Synchronizer holds reset values for two edges; only trust rxs once flushed,
      // and only start frames after the line has really been seen high.
      flush_d     = {flush_q[0], 1'b1};
      armed_d     = armed_q | (flush_q[1] & rxs_q);
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      if (valid_q && ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (armed_q && hist_q && !rxs_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               state_d = rxs_q ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rxs_q;
               if (idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (!rxs_q) begin
                  frame_err_d = 1'b1;
               end else if (valid_q && !ready) begin
                  overrun_d = 1'b1;
               end else begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b1;
         rxs_q       <= 1'b1;
         hist_q      <= 1'b1;
         flush_q     <= 2'b00;
         armed_q     <= 1'b0;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         rxs_q       <= rxs_d;
         hist_q      <= hist_d;
         flush_q     <= flush_d;
         armed_q     <= armed_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - bench for uart_rx: vector table of single frames plus hand-written corner sequences
module tb_uart_rx;

   localparam int PER  = 261;
   localparam int FPER = 51;

   logic       clk = 1'b0;
   logic       rst, rx, ready;
   logic [7:0] data;
   logic       valid, frame_err, overrun, busy;
   logic       rst_f, rx_f;
   logic [7:0] data_f;
   logic       valid_f, frame_err_f, overrun_f, busy_f;

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0] acc_q[$];
   int         ferr_cnt = 0;
   int         ovr_cnt  = 0;
   bit         busy_seen = 1'b0;
   logic [7:0] acc_f[$];
   int         ferr_f = 0;
   int         ovr_f  = 0;

   always #5 clk = ~clk;

   uart_rx dut (
      .clk(clk), .rst(rst), .rx(rx), .ready(ready),
      .data(data), .valid(valid), .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   // Second instance at 51 cycles/bit carries the long message stream.
   uart_rx #(.CLOCK_FREQ(30000000), .BAUD_RATE(600000)) dut_f (
      .clk(clk), .rst(rst_f), .rx(rx_f), .ready(1'b1),
      .data(data_f), .valid(valid_f), .frame_err(frame_err_f), .overrun(overrun_f), .busy(busy_f)
   );

   always @(negedge clk) begin
      if (valid && ready) acc_q.push_back(data);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (busy) busy_seen = 1'b1;
      if (valid_f) acc_f.push_back(data_f);
      if (frame_err_f) ferr_f++;
      if (overrun_f) ovr_f++;
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      acc_q.delete();
      ferr_cnt  = 0;
      ovr_cnt   = 0;
      busy_seen = 1'b0;
   endtask

   task automatic frame_main(input logic [7:0] b, input logic stop_b, input int per);
      rx = 1'b0;
      tick(per);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(per);
      end
      rx = stop_b;
      tick(per);
      rx = 1'b1;
      tick(per);
   endtask

   task automatic frame_fast(input logic [7:0] b, input int per);
      rx_f = 1'b0;
      tick(per);
      for (int i = 0; i < 8; i++) begin
         rx_f = b[i];
         tick(per);
      end
      rx_f = 1'b1;
      tick(2 * per);
   endtask

   typedef struct {
      logic [7:0] b;
      logic       stop_b;
      int         per;
      int         exp_acc;
      logic [7:0] exp_data;
      int         exp_ferr;
   } vec_t;

   vec_t vt[5];

   initial begin
      string msg;
      int    pers[3];
      logic [7:0] b34;

      vt[0] = '{8'h66, 1'b1, PER,     1, 8'h66, 0};
      vt[1] = '{8'h7B, 1'b0, PER,     0, 8'h00, 1};
      vt[2] = '{8'h00, 1'b1, PER,     1, 8'h00, 0};
      vt[3] = '{8'hFF, 1'b1, PER + 5, 1, 8'hFF, 0};
      vt[4] = '{8'hA5, 1'b1, PER - 5, 1, 8'hA5, 0};
      msg     = "flag{FpG4_has_F0Ss_t001cha1n_n0Wwwwww}";
      pers[0] = FPER;
      pers[1] = FPER + 1;
      pers[2] = FPER - 1;

      rst   = 1'b1;
      rst_f = 1'b1;
      rx    = 1'b0;
      rx_f  = 1'b1;
      ready = 1'b1;
      tick(3);
      check("reset_data", int'(data), 0);
      check("reset_valid", int'(valid), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_frame_err", int'(frame_err), 0);
      check("reset_overrun", int'(overrun), 0);

      rst   = 1'b0;
      rst_f = 1'b0;
      clear_mon();
      tick(400);
      check("release_low_busy", int'(busy_seen), 0);
      check("release_low_ferr", ferr_cnt, 0);
      rx = 1'b1;
      tick(10);

      fork
         begin
            for (int i = 0; i < 5; i++) begin
               clear_mon();
               frame_main(vt[i].b, vt[i].stop_b, vt[i].per);
               tick(20);
               check($sformatf("vec%0d_count", i), acc_q.size(), vt[i].exp_acc);
               if (vt[i].exp_acc > 0 && acc_q.size() > 0)
                  check($sformatf("vec%0d_data", i), int'(acc_q[0]), int'(vt[i].exp_data));
               check($sformatf("vec%0d_ferr", i), ferr_cnt, vt[i].exp_ferr);
               check($sformatf("vec%0d_ovr", i), ovr_cnt, 0);
               check($sformatf("vec%0d_valid_idle", i), int'(valid), 0);
            end

            clear_mon();
            rx = 1'b0;
            tick(50);
            rx = 1'b1;
            tick(300);
            check("glitch_busy_seen", int'(busy_seen), 1);
            check("glitch_busy_end", int'(busy), 0);
            check("glitch_count", acc_q.size(), 0);
            check("glitch_ferr", ferr_cnt, 0);

            clear_mon();
            ready = 1'b0;
            frame_main(8'h46, 1'b1, PER);
            frame_main(8'h70, 1'b1, PER);
            tick(20);
            check("ovr_valid", int'(valid), 1);
            check("ovr_data", int'(data), 'h46);
            check("ovr_pulses", ovr_cnt, 1);
            check("ovr_ferr", ferr_cnt, 0);
            ready = 1'b1;
            tick(3);
            check("ovr_cleared", int'(valid), 0);
            check("ovr_accepts", acc_q.size(), 1);
            if (acc_q.size() > 0) check("ovr_accept_data", int'(acc_q[0]), 'h46);

            clear_mon();
            b34 = 8'h34;
            rx  = 1'b0;
            tick(PER);
            for (int i = 0; i < 4; i++) begin
               rx = b34[i];
               tick(PER);
            end
            rx = b34[4];
            tick(PER / 2);
            rst = 1'b1;
            tick(2);
            check("midrst_busy", int'(busy), 0);
            check("midrst_valid", int'(valid), 0);
            rst = 1'b0;
            rx  = 1'b1;
            tick(3 * PER);
            frame_main(8'h5F, 1'b1, PER);
            tick(20);
            check("midrst_count", acc_q.size(), 1);
            if (acc_q.size() > 0) check("midrst_data", int'(acc_q[0]), 'h5F);
            check("midrst_ferr", ferr_cnt, 0);
            check("midrst_ovr", ovr_cnt, 0);
         end
         begin
            tick(10);
            for (int p = 0; p < 3; p++) begin
               acc_f.delete();
               ferr_f = 0;
               ovr_f  = 0;
               for (int k = 0; k < msg.len(); k++) frame_fast(msg[k], pers[p]);
               tick(20);
               check($sformatf("msg%0d_count", p), acc_f.size(), msg.len());
               for (int k = 0; k < msg.len() && k < acc_f.size(); k++)
                  check($sformatf("msg%0d_byte%0d", p, k), int'(acc_f[k]), int'(msg[k]));
               check($sformatf("msg%0d_ferr", p), ferr_f, 0);
               check($sformatf("msg%0d_ovr", p), ovr_f, 0);
            end
         end
      join

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
